seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 125 ++++++++++++
 tb/tb_seg_scan_driver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with shadowed character codes and optional per-digit blink.
// Define SEG_SCAN_BLINK_EN to build the blink counter; otherwise blink_mask is ignored.
module seg_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5*DIGITS-1:0]   codes,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]       r_scanCnt;
  logic [IW-1:0]       r_index;
  logic [5*DIGITS-1:0] r_shadow;

  logic [CW-1:0]       w_nextCnt;
  logic [IW-1:0]       w_nextIdx;
  logic [5*DIGITS-1:0] w_nextShadow;
  logic [4:0]          w_code;
  logic [6:0]          w_glyph;
  logic                w_scanWrap;
  logic                w_dead;
  logic                w_blinked;

  function automatic logic [6:0] decode(input logic [4:0] code);
    case (code)
      5'h00: decode = 7'b1000000;
      5'h01: decode = 7'b1111001;
      5'h02: decode = 7'b0100100;
      5'h03: decode = 7'b0110000;
      5'h04: decode = 7'b0011001;
      5'h05: decode = 7'b0010010;
      5'h06: decode = 7'b0000010;
      5'h07: decode = 7'b1111000;
      5'h08: decode = 7'b0000000;
      5'h09: decode = 7'b0010000;
      5'h0A: decode = 7'b0001000;
      5'h0B: decode = 7'b0000011;
      5'h0C: decode = 7'b1000110;
      5'h0D: decode = 7'b0100001;
      5'h0E: decode = 7'b0000110;
      5'h0F: decode = 7'b0001110;
      5'h10: decode = 7'b0001000;
      5'h11: decode = 7'b0100001;
      5'h12: decode = 7'b0000110;
      5'h13: decode = 7'b1000111;
      5'h14: decode = 7'b1000000;
      5'h15: decode = 7'b0100011;
      5'h16: decode = 7'b0101111;
      5'h17: decode = 7'b0010010;
      5'h18: decode = 7'b0000111;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Outputs are registered from next-state values so seg/an always match the held counter and index.
  always_comb begin
    w_scanWrap   = (r_scanCnt == CW'(SCAN_DIV - 1));
    w_nextCnt    = w_scanWrap ? '0 : r_scanCnt + 1'b1;
    w_nextIdx    = r_index;
    if (w_scanWrap)
      w_nextIdx  = (r_index == IW'(DIGITS - 1)) ? '0 : r_index + 1'b1;
    w_nextShadow = load ? codes : r_shadow;
    w_code       = w_nextShadow[5*w_nextIdx +: 5];
    w_glyph      = decode(w_code);
    w_dead       = (w_nextCnt == '0);
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);

  logic [BW-1:0] r_blinkCnt;
  logic          r_phase;
  logic          w_blinkWrap;
  logic          w_nextPhase;

  always_comb begin
    w_blinkWrap = (r_blinkCnt == BW'(BLINK_DIV - 1));
    w_nextPhase = w_blinkWrap ? ~r_phase : r_phase;
    w_blinked   = w_nextPhase & blink_mask[w_nextIdx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blinkCnt <= '0;
      r_phase    <= 1'b0;
    end else begin
      r_blinkCnt <= w_blinkWrap ? '0 : r_blinkCnt + 1'b1;
      r_phase    <= w_nextPhase;
    end
  end
`else
  always_comb begin
    w_blinked = &{1'b0, blink_mask};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scanCnt <= '0;
      r_index   <= '0;
      r_shadow  <= {DIGITS{5'h1F}};
      seg       <= 7'h7F;
      an        <= '1;
      frame     <= 1'b0;
    end else begin
      r_scanCnt <= w_nextCnt;
      r_index   <= w_nextIdx;
      r_shadow  <= w_nextShadow;
      seg       <= (w_dead || w_blinked) ? 7'h7F : w_glyph;
      an        <= w_dead ? '1 : ~(DIGITS'(1) << w_nextIdx);
      frame     <= (w_nextCnt == CW'(SCAN_DIV - 1)) && (w_nextIdx == IW'(DIGITS - 1));
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver (DIGITS=4, SCAN_DIV=4, BLINK_DIV=8) against a cycle-count model.
module tb_seg_scan_driver;

  localparam int D  = 4;
  localparam int S  = 4;
  localparam int BD = 8;
`ifdef SEG_SCAN_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [5*D-1:0] codes = '0;
  logic [D-1:0] blink_mask = '0;
  logic [6:0]   seg;
  logic [D-1:0] an;
  logic         frame;

  int checks = 0;
  int errors = 0;

  // Model: cycles since the last reset edge plus the loaded shadow contents.
  int         k = 0;
  logic [4:0] mShadow [D];
  logic [6:0] glyph [32];
  logic [6:0] expSeg;
  logic [D-1:0] expAn;
  logic       expFrame;

  seg_scan_driver #(.DIGITS(D), .SCAN_DIV(S), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .codes(codes), .load(load),
    .blink_mask(blink_mask), .seg(seg), .an(an), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic iRst, input logic iLoad, input logic [5*D-1:0] iCodes,
                      input logic [D-1:0] iMask);
    int cnt, idx, phase;
    rst = iRst; load = iLoad; codes = iCodes; blink_mask = iMask;
    @(posedge clk);
    if (iRst) begin
      k = 0;
      for (int d = 0; d < D; d++) mShadow[d] = 5'h1F;
    end else begin
      k++;
      if (iLoad) for (int d = 0; d < D; d++) mShadow[d] = iCodes[5*d +: 5];
    end
    cnt   = k % S;
    idx   = (k / S) % D;
    phase = (k / BD) % 2;
    expAn    = (cnt == 0) ? '1 : ~(D'(1) << idx);
    expFrame = (cnt == S - 1) && (idx == D - 1);
    if (cnt == 0) expSeg = 7'h7F;
    else if (BLINK_EN && phase == 1 && iMask[idx]) expSeg = 7'h7F;
    else expSeg = glyph[mShadow[idx]];
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [5*D-1:0] c;
    c = 20'h18C40;
    tick(1'b1, 1'b1, c, '0);
    tick(1'b1, 1'b1, c, '0);
    checks++;
    if (seg !== 7'h7F || an !== 4'hF || frame !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset seg=%b an=%b frame=%b exp 1111111 1111 0", seg, an, frame);
    end
  endtask

  task automatic test_blank_scan;
    int frames = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'b0, 20'(($urandom)), 4'h0);
      if (frame === 1'b1) frames++;
      checks++;
      if ({seg, an, frame} !== {expSeg, expAn, expFrame}) begin
        errors++;
        $display("[TB] FAIL blank_scan k=%0d seg=%b an=%b frame=%b exp %b %b %b",
                 k, seg, an, frame, expSeg, expAn, expFrame);
      end
    end
    checks++;
    if (frames != 2) begin
      errors++;
      $display("[TB] FAIL frame_count got %0d exp 2", frames);
    end
  endtask

  task automatic test_decode;
    logic [5*D-1:0] c;
    for (int batch = 0; batch < 10; batch++) begin
      if (batch == 0) c = {5'h00, 5'h01, 5'h02, 5'h03};
      else if (batch == 1) c = {4{5'h13}};
      else if (batch == 2) c = {4{5'h19}};
      else if (batch < 10) c = {5'(4*batch), 5'(4*batch+1), 5'(4*batch+2), 5'(4*batch+3)};
      tick(1'b0, 1'b1, c, 4'h0);
      for (int i = 0; i < 16; i++) begin
        tick(1'b0, 1'b0, 20'($urandom), 4'h0);
        checks++;
        if ({seg, an, frame} !== {expSeg, expAn, expFrame}) begin
          errors++;
          $display("[TB] FAIL decode batch=%0d k=%0d seg=%b an=%b frame=%b exp %b %b %b",
                   batch, k, seg, an, frame, expSeg, expAn, expFrame);
        end
      end
    end
  endtask

  task automatic test_load_on_advance;
    logic [5*D-1:0] c;
    logic [4:0] newCode;
    while (k % (S*D) != S - 1) tick(1'b0, 1'b0, '0, 4'h0);
    newCode = 5'h16;
    c = {5'h01, 5'h02, newCode, 5'h03};
    tick(1'b0, 1'b1, c, 4'h0);
    tick(1'b0, 1'b0, '0, 4'h0);
    checks++;
    if (an !== 4'b1101 || seg !== 7'b0101111) begin
      errors++;
      $display("[TB] FAIL load_on_advance an=%b seg=%b exp 1101 0101111", an, seg);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 64; i++) begin
      tick(1'b0, 1'b1, 20'($urandom), 4'h0);
      checks++;
      if ({seg, an, frame} !== {expSeg, expAn, expFrame}) begin
        errors++;
        $display("[TB] FAIL back_to_back k=%0d seg=%b an=%b frame=%b exp %b %b %b",
                 k, seg, an, frame, expSeg, expAn, expFrame);
      end
    end
  endtask

  task automatic test_blink;
    tick(1'b1, 1'b0, '0, 4'h0);
    tick(1'b0, 1'b1, {5'h0A, 5'h09, 5'h08, 5'h05}, 4'b0001);
    for (int i = 0; i < 48; i++) begin
      tick(1'b0, 1'b0, '0, 4'b0001);
      checks++;
      if ({seg, an, frame} !== {expSeg, expAn, expFrame}) begin
        errors++;
        $display("[TB] FAIL blink_fixed k=%0d seg=%b an=%b exp %b %b", k, seg, an, expSeg, expAn);
      end
    end
    for (int i = 0; i < 96; i++) begin
      tick(1'b0, ($urandom_range(0, 3) == 0), 20'($urandom), 4'($urandom));
      checks++;
      if ({seg, an, frame} !== {expSeg, expAn, expFrame}) begin
        errors++;
        $display("[TB] FAIL blink_random k=%0d seg=%b an=%b exp %b %b", k, seg, an, expSeg, expAn);
      end
    end
  endtask

  task automatic test_reset_mid;
    tick(1'b0, 1'b1, {5'h04, 5'h07, 5'h06, 5'h02}, 4'h0);
    while (k % (S*D) != 2*S + 2) tick(1'b0, 1'b0, '0, 4'h0);
    checks++;
    if (an !== 4'b1011) begin
      errors++;
      $display("[TB] FAIL mid_slot_pre an=%b exp 1011", an);
    end
    tick(1'b1, 1'b1, 20'($urandom), 4'hF);
    checks++;
    if (seg !== 7'h7F || an !== 4'hF || frame !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid seg=%b an=%b frame=%b exp 1111111 1111 0", seg, an, frame);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, '0, 4'h0);
      checks++;
      if ({seg, an, frame} !== {expSeg, expAn, expFrame} || seg !== 7'h7F) begin
        errors++;
        $display("[TB] FAIL reset_mid_scan k=%0d seg=%b an=%b frame=%b exp %b %b %b",
                 k, seg, an, frame, expSeg, expAn, expFrame);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) glyph[i] = 7'h7F;
    glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100;
    glyph[3]  = 7'b0110000; glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010;
    glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000; glyph[8]  = 7'b0000000;
    glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
    glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110;
    glyph[15] = 7'b0001110; glyph[16] = 7'b0001000; glyph[17] = 7'b0100001;
    glyph[18] = 7'b0000110; glyph[19] = 7'b1000111; glyph[20] = 7'b1000000;
    glyph[21] = 7'b0100011; glyph[22] = 7'b0101111; glyph[23] = 7'b0010010;
    glyph[24] = 7'b0000111;
    for (int d = 0; d < D; d++) mShadow[d] = 5'h1F;
    @(negedge clk);
    test_reset;
    test_blank_scan;
    test_decode;
    test_load_on_advance;
    test_back_to_back;
    test_blink;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
